// File: rtl/gb_bg_fetcher.sv
// Background/window tile fetcher: walks one row of the tile map, fetches each tile's two
// bitplane bytes from VRAM and hands them to the pixel FIFO over a valid/ready handshake.
module gb_bg_fetcher #(
    parameter logic [12:0] MAP0_BASE   = 13'h1800,
    parameter logic [12:0] MAP1_BASE   = 13'h1C00,
    parameter logic [12:0] SIGNED_BASE = 13'h1000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  tile_x0,
    input  logic [5:0]  tile_count,
    input  logic [4:0]  map_row,
    input  logic [2:0]  fine_y,
    input  logic        map_sel,
    input  logic        data_sel,
    output logic [12:0] vram_addr,
    input  logic [7:0]  vram_q,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [7:0]  px_lo,
    output logic [7:0]  px_hi,
    output logic [4:0]  px_col,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, MAP, MAP_D, TLO, TLO_D, THI, THI_D, PUSH} state_t;

    state_t      state, state_next;
    logic [4:0]  col;
    logic [5:0]  remaining;
    logic [4:0]  row_r;
    logic [2:0]  fine_r;
    logic        map_sel_r;
    logic        data_sel_r;
    logic [5:0]  count_clamped;

    function automatic logic [12:0] map_addr(input logic sel, input logic [4:0] row,
                                             input logic [4:0] c);
        return (sel ? MAP1_BASE : MAP0_BASE) + {3'b000, row, c};
    endfunction

    // Signed mode: the index is sign-extended and scaled by 16; {idx[7], idx, 4'b0}
    // is exactly that value truncated to 13 bits, so the sum wraps naturally.
    function automatic logic [12:0] tile_addr(input logic [7:0] idx, input logic dsel,
                                              input logic [2:0] fy);
        logic [12:0] base;
        base = dsel ? {1'b0, idx, 4'b0000} : SIGNED_BASE + {idx[7], idx, 4'b0000};
        return base + {9'b0, fy, 1'b0};
    endfunction

    assign count_clamped = (tile_count > 6'd32) ? 6'd32 : tile_count;
    assign px_valid      = (state == PUSH);
    assign busy          = (state != IDLE);
    assign px_col        = col;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (count_clamped == 6'd0) ? IDLE : MAP;
            MAP:     state_next = MAP_D;
            MAP_D:   state_next = TLO;
            TLO:     state_next = TLO_D;
            TLO_D:   state_next = THI;
            THI:     state_next = THI_D;
            THI_D:   state_next = PUSH;
            PUSH:    if (px_ready) state_next = (remaining == 6'd1) ? IDLE : MAP;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr  <= '0;
            px_lo      <= '0;
            px_hi      <= '0;
            col        <= '0;
            remaining  <= '0;
            row_r      <= '0;
            fine_r     <= '0;
            map_sel_r  <= 1'b0;
            data_sel_r <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!abort) begin
                case (state)
                    IDLE: if (start) begin
                        col        <= tile_x0;
                        remaining  <= count_clamped;
                        row_r      <= map_row;
                        fine_r     <= fine_y;
                        map_sel_r  <= map_sel;
                        data_sel_r <= data_sel;
                        if (count_clamped == 6'd0) done <= 1'b1;
                        else vram_addr <= map_addr(map_sel, map_row, tile_x0);
                    end
                    // Tile index arrives this cycle; go straight to its low-plane address.
                    MAP_D: vram_addr <= tile_addr(vram_q, data_sel_r, fine_r);
                    TLO_D: begin
                        px_lo     <= vram_q;
                        vram_addr <= vram_addr + 13'd1;
                    end
                    THI_D: px_hi <= vram_q;
                    PUSH: if (px_ready) begin
                        col       <= col + 5'd1;
                        remaining <= remaining - 6'd1;
                        if (remaining == 6'd1) done <= 1'b1;
                        else vram_addr <= map_addr(map_sel_r, row_r, col + 5'd1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
